// File: rtl/aegnn_pkg.sv
// Shared types for the AEGNN ingress path: event record and scheduler state.
package aegnn;
  localparam int TS_W       = 32;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [TS_W-1:0] t;
    logic [7:0]      x;
    logic [7:0]      y;
    logic            p;
  } event_s;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RECOVER} sched_state_e;
endpackage

// File: rtl/aegnn_sync_fifo.sv
// Synchronous FIFO with head visible combinationally, occupancy output and
// single-cycle flush. Push-when-full and pop-when-empty are guarded by the caller.
module aegnn_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/aegnn_event_scheduler.sv
// Ingress scheduler for aegnn_hw: queues events, issues one at a time with a
// data_valid strobe, drops out-of-order timestamps and recovers a hung core.
module aegnn_event_scheduler
  import aegnn::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int CORE_RST_CYC = 8,
  parameter bit MONO_CHECK   = 1'b1,
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  event_s                in_event,
  input  logic                  flush,
  input  logic                  core_ready,
  input  logic                  core_done,
  output logic                  core_data_valid,
  output event_s                core_event,
  output logic                  core_rst,
  output logic                  busy,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  timeout_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RC_W = $clog2(CORE_RST_CYC + 1);

  sched_state_e     state;
  event_s           head;
  logic [WD_W-1:0]  wd_cnt;
  logic [RC_W-1:0]  rc_cnt;
  logic [TS_W-1:0]  last_t;
  logic             have_last;
  logic             push, pop, accept;

  // in_ready comes from the registered count only, so no push+pop at full.
  assign in_ready = fifo_count != CNT_W'(FIFO_DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0) && core_ready && !flush;
  assign accept   = !MONO_CHECK || !have_last || (head.t >= last_t);
  assign busy     = (state != IDLE) || (fifo_count != '0);

  aegnn_sync_fifo #(.WIDTH($bits(event_s)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (in_event),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      core_data_valid <= 1'b0;
      core_event      <= '0;
      core_rst        <= 1'b0;
      drop_count      <= '0;
      timeout_err     <= 1'b0;
      wd_cnt          <= '0;
      rc_cnt          <= '0;
      last_t          <= '0;
      have_last       <= 1'b0;
    end else begin
      core_data_valid <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          if (accept) begin
            core_event      <= head;
            core_data_valid <= 1'b1;
            last_t          <= head.t;
            have_last       <= 1'b1;
            state           <= ISSUE;
          end else if (drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        // Done wins over a same-cycle timeout; the in-flight event is abandoned on recovery.
        WAIT_DONE: begin
          if (core_done) begin
            state <= IDLE;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            state       <= RECOVER;
            core_rst    <= 1'b1;
            timeout_err <= 1'b1;
            rc_cnt      <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (rc_cnt == RC_W'(CORE_RST_CYC - 1)) begin
            core_rst <= 1'b0;
            state    <= IDLE;
          end else begin
            rc_cnt <= rc_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
